// File: rtl/nubus_video_fetch_pkg.sv
// nubus_video_fetch_pkg: shared state encoding and bus widths for the video fetch engine
package nubus_video_fetch_pkg;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, FLUSH} state_t;
endpackage

// File: rtl/vid_fetch_fifo.sv
// vid_fetch_fifo: synchronous FIFO with registered head word and flush
module vid_fetch_fifo
  import nubus_video_fetch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W = DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic do_pop;
  always_comb begin
    do_pop = pop && count_q != '0;
    rd_d = rd_q + AW'(do_pop);
    wr_d = wr_q + AW'(push);
    count_d = count_q + CW'(push) - CW'(do_pop);
    head_d = (count_q == '0 || (do_pop && count_q == CW'(1))) ? (push ? din : head_q) :
             do_pop ? mem_q[rd_q + 1'b1] : head_q;
    if (flush) begin
      rd_d = '0;
      wr_d = '0;
      count_d = '0;
      head_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      head_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      head_q <= head_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= din;
  end
  assign head = head_q;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign count = count_q;
endmodule

// File: rtl/nubus_video_fetch.sv
// nubus_video_fetch: scan-out prefetch engine reading one frame from VRAM into a pixel FIFO
module nubus_video_fetch
  import nubus_video_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_WORDS = 49152,
  parameter int REQ_CYCLES = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd,
  output logic              vram_wr,
  output logic [DATA_W-1:0] vram_dout,
  input  logic [DATA_W-1:0] vram_din,
  input  logic              vram_ready,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  output logic              frame_done
);
  localparam int WW = $clog2(FRAME_WORDS+1);
  localparam int RW = $clog2(REQ_CYCLES+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WW-1:0] words_q, words_d;
  logic [RW-1:0] req_q, req_d;
  logic [TW-1:0] wait_q, wait_d;
  logic underflow_q, underflow_d, done_q, done_d;
  logic push, flush, empty, full;
  logic [CW-1:0] count;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    words_d = words_q;
    req_d = req_q;
    wait_d = wait_q;
    done_d = done_q;
    push = 1'b0;
    flush = 1'b0;
    underflow_d = underflow_q | (pix_pop & empty);
    case (state_q)
      CHECK: begin
        if (words_q == WW'(FRAME_WORDS)) begin
          done_d = 1'b1;
          state_d = IDLE;
        end else if (count < CW'(FIFO_DEPTH)) begin
          req_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        req_d = req_q + 1'b1;
        wait_d = '0;
        state_d = req_q == RW'(REQ_CYCLES-1) ? WAIT : REQ;
      end
      WAIT: begin
        wait_d = wait_q + 1'b1;
        req_d = '0;
        if (vram_ready) begin
          push = 1'b1;
          addr_d = addr_q + 1'b1;
          words_d = words_q + 1'b1;
          state_d = CHECK;
        end else if (wait_q == TW'(TIMEOUT-1)) begin
          state_d = REQ;
        end
      end
      FLUSH: begin
        wait_d = wait_q + 1'b1;
        state_d = wait_q == TW'(TIMEOUT-1) ? CHECK : FLUSH;
      end
      default: state_d = state_q;
    endcase
    // a restart mid-fetch parks in FLUSH so a late completion cannot land in the new frame
    if (frame_start) begin
      push = 1'b0;
      flush = state_q != IDLE;
      addr_d = base_addr;
      words_d = '0;
      wait_d = '0;
      underflow_d = 1'b0;
      done_d = 1'b0;
      state_d = state_q == IDLE ? CHECK : FLUSH;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      words_q <= '0;
      req_q <= '0;
      wait_q <= '0;
      underflow_q <= 1'b0;
      done_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      words_q <= words_d;
      req_q <= req_d;
      wait_q <= wait_d;
      underflow_q <= underflow_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && full));
  end
  vid_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push(push),
    .pop(pix_pop),
    .flush(flush),
    .din(vram_din),
    .head(pix_data),
    .empty(empty),
    .full(full),
    .count(count)
  );
  assign vram_addr = addr_q;
  assign vram_rd = state_q == REQ;
  assign vram_wr = 1'b0;
  assign vram_dout = '0;
  assign pix_valid = !empty;
  assign underflow = underflow_q;
  assign frame_done = done_q;
endmodule
